// File: rtl/mac_cache_ctrl_if.sv
// rtl/mac_cache_ctrl_if.sv - insert, lookup and dump signal bundle for mac_cache_ctrl
interface mac_cache_ctrl_if #(
    parameter int TAGSIZE = 16,
    parameter int CTRSIZE = 16,
    parameter int DEPTH   = 64
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               in_valid;
    logic               in_ready;
    logic [TAGSIZE-1:0] in_tag;
    logic [CTRSIZE-1:0] in_ctr;
    logic               lk_valid;
    logic [TAGSIZE-1:0] lk_tag;
    logic               lk_done;
    logic               lk_hit;
    logic [CTRSIZE-1:0] lk_ctr;
    logic               rd_start;
    logic               rd_reverse;
    logic               rd_valid;
    logic               rd_ready;
    logic [TAGSIZE-1:0] rd_tag;
    logic [CTRSIZE-1:0] rd_ctr;
    logic               rd_last;
    logic [CW-1:0]      count;

    modport master (
        output in_valid, in_tag, in_ctr, lk_valid, lk_tag, rd_start, rd_reverse, rd_ready,
        input  in_ready, lk_done, lk_hit, lk_ctr, rd_valid, rd_tag, rd_ctr, rd_last, count
    );

    modport slave (
        input  in_valid, in_tag, in_ctr, lk_valid, lk_tag, rd_start, rd_reverse, rd_ready,
        output in_ready, lk_done, lk_hit, lk_ctr, rd_valid, rd_tag, rd_ctr, rd_last, count
    );
endinterface

// File: rtl/mac_cache_ctrl.sv
// rtl/mac_cache_ctrl.sv - MAC tag ring cache with lookup and fwd/rev dump; optional MAC_CACHE_DEDUP_EN
module mac_cache_ctrl #(
    parameter int TAGSIZE = 16,
    parameter int CTRSIZE = 16,
    parameter int DEPTH   = 64
) (
    input logic             clk,
    input logic             rst,
    mac_cache_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, DUMP} state_t;

    state_t             state, state_next;
    logic [TAGSIZE-1:0] tag_mem [DEPTH];
    logic [CTRSIZE-1:0] ctr_mem [DEPTH];
    logic [AW-1:0]      wp, wp_n, rp, slot;
    logic [CW-1:0]      count, count_n, beat;
    logic               reverse;
    logic               in_ready_q;
    logic               lk_done_q, lk_hit_q;
    logic [CTRSIZE-1:0] lk_ctr_q;
    logic               lk_match;
    logic [CTRSIZE-1:0] lk_match_ctr;
    logic               ins_fire, ins_alloc, rd_fire, rd_last_w, dump_go;
`ifdef MAC_CACHE_DEDUP_EN
    logic               dd_match;
    logic [AW-1:0]      dd_slot;
`endif

    // in_ready_q tracks (state == IDLE) but stays low while in reset
    assign ins_fire  = bus.in_valid && in_ready_q;
    assign rd_fire   = (state == DUMP) && bus.rd_ready;
    assign rd_last_w = (state == DUMP) && (beat == count);
    assign dump_go   = (state == IDLE) && bus.rd_start && (count != '0);

    // Scan entries oldest to newest so the newest match is the one left standing
    always_comb begin
        lk_match     = 1'b0;
        lk_match_ctr = '0;
        slot         = '0;
`ifdef MAC_CACHE_DEDUP_EN
        dd_match     = 1'b0;
        dd_slot      = '0;
`endif
        for (int k = DEPTH - 1; k >= 0; k--) begin
            slot = wp - AW'(k + 1);
            if (CW'(k) < count) begin
                if (tag_mem[slot] == bus.lk_tag) begin
                    lk_match     = 1'b1;
                    lk_match_ctr = ctr_mem[slot];
                end
`ifdef MAC_CACHE_DEDUP_EN
                if (tag_mem[slot] == bus.in_tag) begin
                    dd_match = 1'b1;
                    dd_slot  = slot;
                end
`endif
            end
        end
    end

    // Post-insert ring pointers, so a dump started alongside an insert sees it
    always_comb begin
        ins_alloc = ins_fire;
`ifdef MAC_CACHE_DEDUP_EN
        ins_alloc = ins_fire && !dd_match;
`endif
        wp_n    = wp;
        count_n = count;
        if (ins_alloc) begin
            wp_n = wp + AW'(1);
            if (count != CW'(DEPTH))
                count_n = count + CW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next state: start a dump only with something to send, leave after the last beat
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (dump_go) state_next = DUMP;
            DUMP: if (rd_fire && rd_last_w) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ring pointers, occupancy and dump cursor
    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            count      <= '0;
            rp         <= '0;
            beat       <= '0;
            reverse    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_next == IDLE);
            wp         <= wp_n;
            count      <= count_n;
            if (dump_go) begin
                reverse <= bus.rd_reverse;
                beat    <= CW'(1);
                rp      <= bus.rd_reverse ? (wp_n - AW'(1)) : (wp_n - count_n[AW-1:0]);
            end else if (rd_fire) begin
                beat <= beat + CW'(1);
                rp   <= reverse ? (rp - AW'(1)) : (rp + AW'(1));
            end
        end
    end

    // Entry storage; qualified by count so it is never cleared
    always_ff @(posedge clk) begin
        if (ins_fire) begin
            if (ins_alloc) begin
                tag_mem[wp] <= bus.in_tag;
                ctr_mem[wp] <= bus.in_ctr;
            end
`ifdef MAC_CACHE_DEDUP_EN
            else begin
                ctr_mem[dd_slot] <= bus.in_ctr;
            end
`endif
        end
    end

    // Registered lookup result, one cycle after the request
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_done_q <= 1'b0;
            lk_hit_q  <= 1'b0;
            lk_ctr_q  <= '0;
        end else begin
            lk_done_q <= bus.lk_valid;
            lk_hit_q  <= bus.lk_valid && lk_match;
            lk_ctr_q  <= (bus.lk_valid && lk_match) ? lk_match_ctr : '0;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.lk_done  = lk_done_q;
    assign bus.lk_hit   = lk_hit_q;
    assign bus.lk_ctr   = lk_ctr_q;
    assign bus.rd_valid = (state == DUMP);
    assign bus.rd_tag   = (state == DUMP) ? tag_mem[rp] : '0;
    assign bus.rd_ctr   = (state == DUMP) ? ctr_mem[rp] : '0;
    assign bus.rd_last  = rd_last_w;
    assign bus.count    = count;
endmodule

// File: tb/tb_mac_cache_ctrl.sv
// tb/tb_mac_cache_ctrl.sv - self-checking bench for mac_cache_ctrl with DEPTH=4
module tb_mac_cache_ctrl;
    localparam int TAGSIZE = 16;
    localparam int CTRSIZE = 16;
    localparam int DEPTH   = 4;
`ifdef MAC_CACHE_DEDUP_EN
    localparam int DUP = 1;
`else
    localparam int DUP = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_cache_ctrl_if #(.TAGSIZE(TAGSIZE), .CTRSIZE(CTRSIZE), .DEPTH(DEPTH)) bus ();
    mac_cache_ctrl #(.TAGSIZE(TAGSIZE), .CTRSIZE(CTRSIZE), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {bit [15:0] tag; bit [15:0] ctr; bit last;} beat_t;
    typedef struct {bit hit; bit [15:0] ctr;} lk_t;
    typedef struct {
        bit ins; bit [15:0] itag; bit [15:0] ictr;
        bit lk;  bit [15:0] ltag; bit exp_hit; bit [15:0] exp_ctr;
        int exp_count;
    } vec_t;

    beat_t beat_q[$];
    lk_t   lk_q[$];
    vec_t  vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input bit ins, input bit [15:0] itag, input bit [15:0] ictr,
                           input bit lk, input bit [15:0] ltag, input bit eh, input bit [15:0] ec,
                           input int cnt);
        vec_t v;
        v = '{ins, itag, ictr, lk, ltag, eh, ec, cnt};
        vecs.push_back(v);
    endtask

    task automatic push_beat(input bit [15:0] tag, input bit [15:0] ctr, input bit last);
        beat_t b;
        b = '{tag, ctr, last};
        beat_q.push_back(b);
    endtask

    // Scoreboard: lookup results and dump beats checked as the DUT produces them
    logic        lk_req_d = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_tag = '0;
    always @(posedge clk) lk_req_d <= rst ? 1'b0 : bus.lk_valid;

    always @(negedge clk) begin
        lk_t   le;
        beat_t be;
        if (!rst) begin
            check("lk_done_timing", bus.lk_done, lk_req_d);
            if (bus.lk_done) begin
                if (lk_q.size() == 0) begin
                    errors++;
                    $display("FAIL lk_unexpected: lk_done with no pending lookup");
                end else begin
                    le = lk_q.pop_front();
                    check("lk_hit", bus.lk_hit, le.hit);
                    check("lk_ctr", bus.lk_ctr, le.ctr);
                end
            end
            if (bus.rd_valid) check("in_ready_in_dump", bus.in_ready, 0);
            if (prev_stall) begin
                check("stall_valid", bus.rd_valid, 1);
                check("stall_tag", bus.rd_tag, prev_tag);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: tag 0x%0h accepted with none expected", bus.rd_tag);
                end else begin
                    be = beat_q.pop_front();
                    check("beat_tag", bus.rd_tag, be.tag);
                    check("beat_ctr", bus.rd_ctr, be.ctr);
                    check("beat_last", bus.rd_last, be.last);
                end
            end
            prev_stall = bus.rd_valid && !bus.rd_ready;
            prev_tag   = bus.rd_tag;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_lk_done", bus.lk_done, 0);
        check("rst_lk_hit", bus.lk_hit, 0);
        check("rst_lk_ctr", bus.lk_ctr, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_tag", bus.rd_tag, 0);
        check("rst_rd_ctr", bus.rd_ctr, 0);
        check("rst_rd_last", bus.rd_last, 0);
        check("rst_count", bus.count, 0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", bus.in_ready, 1);
    endtask

    task automatic run_vectors();
        foreach (vecs[i]) begin
            bus.in_valid = vecs[i].ins;
            bus.in_tag   = vecs[i].itag;
            bus.in_ctr   = vecs[i].ictr;
            bus.lk_valid = vecs[i].lk;
            bus.lk_tag   = vecs[i].ltag;
            if (vecs[i].lk) begin
                lk_t e;
                e = '{vecs[i].exp_hit, vecs[i].exp_ctr};
                lk_q.push_back(e);
            end
            if (vecs[i].ins) check($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
            step();
            check($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_count);
        end
        bus.in_valid = 1'b0;
        bus.lk_valid = 1'b0;
        step();
        check("lk_drained", lk_q.size(), 0);
        vecs.delete();
    endtask

    task automatic dump(input bit rev, input bit toggle, input int exp_count);
        int n;
        bus.rd_start   = 1'b1;
        bus.rd_reverse = rev;
        bus.rd_ready   = 1'b0;
        step();
        bus.rd_start   = 1'b0;
        bus.rd_reverse = 1'b0;
        check("dump_first_valid", bus.rd_valid, 1);
        n = 0;
        while (beat_q.size() > 0 && n < 40) begin
            bus.rd_ready = toggle ? ((n % 2) == 0) : 1'b1;
            step();
            n++;
            if (beat_q.size() > 0) check("dump_count", bus.count, exp_count);
        end
        check("dump_beats_left", beat_q.size(), 0);
        bus.rd_ready = 1'b0;
        check("dump_in_ready_after", bus.in_ready, 1);
        check("dump_valid_after", bus.rd_valid, 0);
        check("dump_count_after", bus.count, exp_count);
        beat_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 0; bus.in_tag = 0; bus.in_ctr = 0;
        bus.lk_valid = 0; bus.lk_tag = 0;
        bus.rd_start = 0; bus.rd_reverse = 0; bus.rd_ready = 0;
        rst = 1'b1;

        // Basic fill with lookups, including same-cycle insert/lookup miss
        reset_dut();
        add_vec(1, 16'h11, 16'h1, 1, 16'h11, 0, 16'h0, 1);
        add_vec(1, 16'h22, 16'h2, 1, 16'h11, 1, 16'h1, 2);
        add_vec(1, 16'h33, 16'h3, 1, 16'h33, 0, 16'h0, 3);
        add_vec(0, 16'h00, 16'h0, 1, 16'h33, 1, 16'h3, 3);
        add_vec(0, 16'h00, 16'h0, 1, 16'h44, 0, 16'h0, 3);
        add_vec(0, 16'h00, 16'h0, 1, 16'h22, 1, 16'h2, 3);
        run_vectors();

        push_beat(16'h11, 16'h1, 0);
        push_beat(16'h22, 16'h2, 0);
        push_beat(16'h33, 16'h3, 1);
        dump(0, 0, 3);

        push_beat(16'h33, 16'h3, 0);
        push_beat(16'h22, 16'h2, 0);
        push_beat(16'h11, 16'h1, 1);
        dump(1, 1, 3);

        // Wrap past DEPTH: oldest two overwritten
        reset_dut();
        for (int i = 1; i <= 6; i++)
            add_vec(1, 16'(i), 16'(16'h100 + i), 0, 16'h0, 0, 16'h0, (i < DEPTH) ? i : DEPTH);
        add_vec(0, 16'h0, 16'h0, 1, 16'h02, 0, 16'h0,   4);
        add_vec(0, 16'h0, 16'h0, 1, 16'h03, 1, 16'h103, 4);
        add_vec(0, 16'h0, 16'h0, 1, 16'h06, 1, 16'h106, 4);
        run_vectors();
        for (int i = 3; i <= 6; i++) push_beat(16'(i), 16'(16'h100 + i), i == 6);
        dump(0, 0, 4);

        // Duplicate tags and same-cycle visibility of 0x77
        reset_dut();
        add_vec(1, 16'hAA, 16'h5, 0, 16'h00, 0, 16'h0, 1);
        add_vec(1, 16'hAA, 16'h9, 1, 16'hAA, 1, 16'h5, 2 - DUP);
        add_vec(0, 16'h00, 16'h0, 1, 16'hAA, 1, 16'h9, 2 - DUP);
        add_vec(1, 16'h77, 16'h7, 1, 16'h77, 0, 16'h0, 3 - DUP);
        add_vec(0, 16'h00, 16'h0, 1, 16'h77, 1, 16'h7, 3 - DUP);
        run_vectors();
        push_beat(16'h77, 16'h7, 0);
        push_beat(16'hAA, 16'h9, DUP == 1);
        if (DUP == 0) push_beat(16'hAA, 16'h5, 1);
        dump(1, 0, 3 - DUP);

        // Reset asserted on the second beat of a three-entry dump
        reset_dut();
        add_vec(1, 16'h11, 16'h1, 0, 16'h0, 0, 16'h0, 1);
        add_vec(1, 16'h22, 16'h2, 0, 16'h0, 0, 16'h0, 2);
        add_vec(1, 16'h33, 16'h3, 0, 16'h0, 0, 16'h0, 3);
        run_vectors();
        push_beat(16'h11, 16'h1, 0);
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
        bus.rd_ready = 1'b1;
        step();
        check("abort_beat2_valid", bus.rd_valid, 1);
        check("abort_beat2_tag", bus.rd_tag, 16'h22);
        check("abort_beat1_taken", beat_q.size(), 0);
        rst = 1'b1;
        bus.rd_ready = 1'b0;
        step();
        check("abort_rd_valid", bus.rd_valid, 0);
        check("abort_count", bus.count, 0);
        rst = 1'b0;
        step();
        bus.rd_start = 1'b1;
        bus.rd_ready = 1'b1;
        step();
        bus.rd_start = 1'b0;
        check("empty_start_valid", bus.rd_valid, 0);
        check("empty_start_in_ready", bus.in_ready, 1);
        step();
        check("empty_start_valid2", bus.rd_valid, 0);
        bus.rd_ready = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_cache_ctrl.md
# mac_cache_ctrl

Parametrised MAC tag cache for the chaffing-and-winnowing datapath. It stores up to DEPTH {tag, counter} entries in a ring with oldest-overwrite on full. It answers single-cycle-latency winnowing lookups: does this tag exist, and with which counter. It can dump its whole contents in forward (oldest-first) or reverse (newest-first) order over a valid/ready stream. It replaces the fixed-size, reverse-only, combinationally-copied cache with a stateful, handshaked block.

## Interface
- TAGSIZE, 16, width of a MAC tag
- CTRSIZE, 16, width of the counter stored with each tag
- DEPTH, 64, number of entries; power of two, at least 2
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  insert request
- in_ready  out  1  insert accepted when in_valid && in_ready
- in_tag  in  TAGSIZE  tag to insert
- in_ctr  in  CTRSIZE  counter to insert
- lk_valid  in  1  lookup request (no backpressure)
- lk_tag  in  TAGSIZE  tag to look up
- lk_done  out  1  lookup result valid (one-cycle pulse)
- lk_hit  out  1  tag found
- lk_ctr  out  CTRSIZE  counter of the newest matching entry; 0 on miss
- rd_start  in  1  begin dump (sampled in IDLE only)
- rd_reverse  in  1  dump order: 0 = oldest-first, 1 = newest-first; sampled with rd_start
- rd_valid  out  1  dump beat valid
- rd_ready  in  1  dump beat consumed when rd_valid && rd_ready
- rd_tag  out  TAGSIZE  dump beat tag
- rd_ctr  out  CTRSIZE  dump beat counter
- rd_last  out  1  final dump beat
- count  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Storage: DEPTH-entry ring with write pointer wp (slot of next insert) and count. The oldest entry sits at (wp - count) mod DEPTH.
- FSM has two states, IDLE and DUMP.
- IDLE:
  - in_ready = 1.
  - An accepted insert writes slot wp and increments wp mod DEPTH.
  - count saturates at DEPTH. At full, the insert overwrites the oldest entry.
- IDLE to DUMP: on rd_start with count > 0. rd_start with count == 0 is ignored; rd_valid never asserts for it.
- DUMP:
  - in_ready = 0; inserts stall.
  - One entry is presented per accepted beat, holding stable while rd_valid && !rd_ready.
  - Forward order starts at the oldest entry and advances +1. Reverse order starts at wp-1 and advances -1, both mod DEPTH.
  - rd_last = 1 on beat number count; after that beat is accepted the FSM returns to IDLE.
  - Contents are not modified by a dump.
- Lookup is accepted in any state:
  - Compares lk_tag in parallel against all valid entries.
  - On multiple matches, the newest (closest to wp-1) wins.
  - The lookup sees storage as it was before any insert accepted in the same cycle.
- rst clears count, wp and the FSM (to IDLE), and zeroes all registered outputs. Entry storage need not be cleared; entries are qualified by count.

## Timing
- Lookup latency is 1 cycle: lk_valid at cycle N gives lk_done/lk_hit/lk_ctr at N+1, all registered.
  - lk_done = 0 in cycles with no preceding request.
  - Back-to-back lookups give back-to-back results.
- An insert becomes visible to lookups and dumps from the cycle after acceptance.
- Dump:
  - First rd_valid in the cycle after rd_start.
  - Throughput is 1 beat/cycle with rd_ready held high.
  - A count-entry dump occupies count cycles plus stalls.
  - in_ready rises in the cycle after the rd_last beat is accepted.
- Reset values: in_ready = 0 while rst is high and 1 in the first cycle after it; lk_done, lk_hit, lk_ctr, rd_valid, rd_tag, rd_ctr, rd_last and count are all 0.
- rst asserted mid-dump: the dump aborts that cycle, rd_valid = 0 next cycle, and the cache is empty.
- rd_start while in DUMP is ignored.

## Configuration
- MAC_CACHE_DEDUP_EN defined:
  - An accepted insert whose in_tag matches a valid entry overwrites that entry's counter in place; the newest match is chosen if there are several.
  - wp and count are unchanged by such an insert.
- MAC_CACHE_DEDUP_EN undefined: every accepted insert allocates a new slot, so duplicates coexist and the newest wins on lookup.

## Test plan
- Reset with DEPTH=4: insert tags 0x11,0x22,0x33, then dump forward -> beats 0x11,0x22,0x33, rd_last on 0x33, count=3 throughout.
- Same contents dumped reverse with rd_ready toggling 1,0,1,0 -> beats 0x33,0x22,0x11, each held during stall cycles, in_ready=0 until the cycle after the last beat.
- Wrap: insert 6 tags 0x01..0x06 into DEPTH=4 -> count=4, forward dump 0x03..0x06, lookup 0x02 -> lk_hit=0, lk_ctr=0 at N+1.
- Duplicate: insert 0xAA/ctr 5, then 0xAA/ctr 9, lookup 0xAA -> lk_hit=1, lk_ctr=9. Without the macro count=2; with MAC_CACHE_DEDUP_EN count=1.
- Insert of 0x77 and lookup of 0x77 in the same cycle -> miss; repeat lookup next cycle -> hit.
- rst asserted on the 2nd beat of a 3-entry dump -> rd_valid=0 next cycle, count=0; rd_start afterwards produces no beats.
